tcbcnn_job_scheduler: RTL
=========================

Name: tcbcnn_job_scheduler

Overview:
Arbitrates one shared tcbcnn inference core between two requesters. Each requester is an AXI-stream ingest front end holding a fully assembled image. The scheduler round-robin grants one requester and latches its image onto the core. It holds the core's valid high until ready or a watchdog timeout, then returns the prediction tagged with requester id and timeout status. It sits between the per-channel input buffers and the tcbcnn core, and drives the result path to the output streamer.

Parameters:
DATA_WIDTH, 32, width of one image word and of the prediction result
NUMBER_OF_INPUT_WORDS, 32, image words per job; image bus is DATA_WIDTH*NUMBER_OF_INPUT_WORDS bits
TIMEOUT_CYCLES, 4096, maximum RUN cycles before a job is aborted (must be ≥2)

Ports:
axi_clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an image ready
req0_img  in  DATA_WIDTH*NUMBER_OF_INPUT_WORDS  requester 0 image
req0_ready  out  1  grant/accept strobe to requester 0
req1_valid  in  1  requester 1 has an image ready
req1_img  in  DATA_WIDTH*NUMBER_OF_INPUT_WORDS  requester 1 image
req1_ready  out  1  grant/accept strobe to requester 1
core_img  out  DATA_WIDTH*NUMBER_OF_INPUT_WORDS  registered image to core
core_valid  out  1  run request to core
core_ready  in  1  core done; core_number valid
core_number  in  DATA_WIDTH  core prediction
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  DATA_WIDTH  prediction (0 on timeout)
res_id  out  1  requester that owns the result
res_timeout  out  1  job aborted by watchdog
timeout_count  out  16  saturating count of aborted jobs
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, core_img=0, res_data=0, res_id=0, res_timeout=0, timeout_count=0, timer=0, last_grant=1 (requester 0 wins first contention). All outputs decoded from these values are therefore 0: core_valid=0, res_valid=0, req0_ready=0, req1_ready=0, busy=0. A reset mid-job discards the job; no result is emitted.
- States: IDLE, RUN, RESULT.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, grant N. If both are high, grant the requester that is not last_grant.
  - reqN_ready=1 for the granted requester only, and only in IDLE. A handshake is reqN_valid & reqN_ready.
  - On the handshake edge: core_img<=reqN_img; res_id<=N; last_grant<=N; timer<=0; state->RUN.
  - No requester valid: stay in IDLE.
- RUN:
  - core_valid=1, decoded from state; first high in the cycle after the grant edge. core_img is stable for the whole of RUN.
  - Both reqN_ready are 0. Requester valids are ignored, not queued.
  - core_ready=1 at an edge: res_data<=core_number; res_timeout<=0; state->RESULT.
  - Otherwise, at timer==TIMEOUT_CYCLES-1: res_data<=0; res_timeout<=1; timeout_count<=timeout_count+1, saturating at 0xFFFF; state->RESULT.
  - Otherwise: timer<=timer+1.
  - core_ready and the timeout terminal count at the same edge: core_ready wins, no timeout.
  - RUN lasts at most TIMEOUT_CYCLES cycles.
- RESULT:
  - res_valid=1; core_valid=0. This guarantees at least one low cycle on core_valid between jobs, so the core can clear ready.
  - res_data, res_id and res_timeout hold until the handshake. On res_valid & res_ready: state->IDLE.
  - res_ready low: hold indefinitely; requesters stay blocked (backpressure).
- Latency: grant edge E0; core_valid high from E0 to the core_ready edge Ek; res_valid high from Ek. The earliest re-grant is in the IDLE cycle after the result handshake, which gives a minimum job period of 3 cycles with a single-cycle core.
- Timer width is clogb2(TIMEOUT_CYCLES). core_ready seen outside RUN is ignored.

Test Plan:
- Single job: req0_valid with img word0=0x11; core_ready asserted 5 cycles after core_valid rises with core_number=7 -> core_img word0=0x11; res_valid=1 with res_data=7, res_id=0, res_timeout=0; core_valid high for exactly 5 cycles.
- Contention: both valids held high continuously, core_ready returned after 2 cycles each, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; never two grants without an intervening result.
- Timeout: TIMEOUT_CYCLES=8, core_ready held 0 -> core_valid high exactly 8 cycles; res_data=0, res_timeout=1, timeout_count=1; next job completes normally with res_timeout=0.
- Tie at terminal count: core_ready=1 on the same edge that timer==TIMEOUT_CYCLES-1 -> res_timeout=0, res_data=core_number, timeout_count unchanged.
- Backpressure: res_ready low for 20 cycles, req1_valid high -> res fields stable, req1_ready=0, core_valid=0 throughout; req1 is granted in the cycle after res_ready rises.
- Async reset mid-RUN: assert rst off a clock edge -> core_valid, busy and res_valid drop immediately; after release, req1_valid and req0_valid both high -> req0 granted first.

Source files
------------

// File: rtl/tcbcnn_job_scheduler.sv
// -----------------------------------------------------------------------------
// tcbcnn_job_scheduler
//
// Purpose:
//   Shares one tcbcnn inference core between two image requesters. The
//   requesters are granted round-robin. The granted image is latched onto the
//   core and core_valid is held high until the core answers or a watchdog
//   expires. The prediction is then presented on the result port, tagged with
//   the owning requester and with a timeout flag.
//
// Ports:
//   axi_clk, rst            clock and asynchronous active-high reset
//   req0_valid/img/ready    requester 0 handshake and image
//   req1_valid/img/ready    requester 1 handshake and image
//   core_img, core_valid    image and run request driven to the core
//   core_ready, core_number core completion strobe and prediction
//   res_valid/ready         result handshake to the output streamer
//   res_data/id/timeout     prediction, owner and watchdog-abort flag
//   timeout_count           saturating count of aborted jobs
//   busy                    scheduler is not idle
// -----------------------------------------------------------------------------
module tcbcnn_job_scheduler #(
    parameter int DATA_WIDTH            = 32,
    parameter int NUMBER_OF_INPUT_WORDS = 32,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                                        axi_clk,
    input  logic                                        rst,
    input  logic                                        req0_valid,
    input  logic [DATA_WIDTH*NUMBER_OF_INPUT_WORDS-1:0] req0_img,
    output logic                                        req0_ready,
    input  logic                                        req1_valid,
    input  logic [DATA_WIDTH*NUMBER_OF_INPUT_WORDS-1:0] req1_img,
    output logic                                        req1_ready,
    output logic [DATA_WIDTH*NUMBER_OF_INPUT_WORDS-1:0] core_img,
    output logic                                        core_valid,
    input  logic                                        core_ready,
    input  logic [DATA_WIDTH-1:0]                       core_number,
    output logic                                        res_valid,
    input  logic                                        res_ready,
    output logic [DATA_WIDTH-1:0]                       res_data,
    output logic                                        res_id,
    output logic                                        res_timeout,
    output logic [15:0]                                 timeout_count,
    output logic                                        busy
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic                 last_grant;
    logic                 grant0;
    logic                 grant1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin: on contention the requester that did not win last time
    // is preferred; a lone requester always wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign core_valid = (state == RUN);
    assign res_valid  = (state == RESULT);
    assign busy       = (state != IDLE);

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            core_img      <= '0;
            res_data      <= '0;
            res_id        <= 1'b0;
            res_timeout   <= 1'b0;
            timeout_count <= 16'd0;
            timer         <= '0;
            last_grant    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        core_img   <= req0_img;
                        res_id     <= 1'b0;
                        last_grant <= 1'b0;
                        timer      <= '0;
                        state      <= RUN;
                    end else if (grant1) begin
                        core_img   <= req1_img;
                        res_id     <= 1'b1;
                        last_grant <= 1'b1;
                        timer      <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // A core answer on the terminal-count edge still counts
                    // as a normal completion.
                    if (core_ready) begin
                        res_data    <= core_number;
                        res_timeout <= 1'b0;
                        state       <= RESULT;
                    end else if (timer == TIMER_LAST) begin
                        res_data      <= '0;
                        res_timeout   <= 1'b1;
                        timeout_count <= sat_inc16(timeout_count);
                        state         <= RESULT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RESULT: begin
                    // Leaving RUN through RESULT forces core_valid low for at
                    // least one cycle between jobs.
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
